// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB-first, optional
// parity bit, stop bit. Each bit is held for the latched Prescale clocks.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic [5:0]            Prescale,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic [5:0]            presc_q, presc_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;

   logic [5:0]            presc_eff;
   logic                  bit_done;
   logic [IW-1:0]         idx_nxt;

   // Very short bit periods are clamped so a frame always has a sane minimum width.
   assign presc_eff = (Prescale < 6'd4) ? 6'd4 : Prescale;
   assign bit_done  = (cnt_q == (presc_q - 6'd1));
   assign idx_nxt   = idx_q + IW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      presc_d   = presc_q;
      tx_d      = tx_q;
      busy_d    = busy_q;

      if (state_q != S_IDLE) begin
         cnt_d = bit_done ? 6'd0 : (cnt_q + 6'd1);
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = 6'd0;
            idx_d = '0;
            tx_d  = 1'b1;
            busy_d = 1'b0;
            if (Data_Valid) begin
               data_d    = P_DATA;
               par_en_d  = parity_enable;
               par_bit_d = (^P_DATA) ^ parity_type;
               presc_d   = presc_eff;
               state_d   = S_START;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d = S_DATA;
               idx_d   = '0;
               tx_d    = data_q[0];
            end
         end
         S_DATA: begin
            if (bit_done) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_nxt;
                  tx_d  = data_q[idx_nxt];
               end
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            // Busy falls together with the return to IDLE so the next
            // request can be taken on the very first idle cycle.
            if (bit_done) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         idx_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         presc_q   <= 6'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         presc_q   <= presc_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: checks line level and Busy every cycle
// of each frame against a bench-side frame model, plus a mid-bit deserializer.
module tb_uart_tx_serializer;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       parity_enable;
   logic       parity_type;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   uart_tx_serializer #(.DATA_WIDTH(8)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .P_DATA       (P_DATA),
      .Data_Valid   (Data_Valid),
      .parity_enable(parity_enable),
      .parity_type  (parity_type),
      .Prescale     (Prescale),
      .TX_OUT       (TX_OUT),
      .Busy         (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present a request and wait through the acceptance edge.
   task automatic req(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] presc);
      P_DATA        = d;
      parity_enable = pe;
      parity_type   = pt;
      Prescale      = presc;
      Data_Valid    = 1'b1;
      step();
   endtask

   task automatic idle_for(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk({tag, "_tx"}, 32'(TX_OUT), 32'd1);
         chk({tag, "_busy"}, 32'(Busy), 32'd0);
      end
   endtask

   // Called right after the acceptance edge. Checks every cycle of the frame,
   // optionally injects a mid-frame request or a reset.
   task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input int p, input int inj,
                              input int rst_at, input logic hold_dv, input logic [7:0] next_d);
      int         nbits;
      int         k;
      logic       exp_bit;
      logic       par;
      logic [7:0] rx;
      logic       rx_par;
      logic       rx_stop;
      nbits   = 10 + int'(pe);
      par     = pt ? ~(^d) : (^d);
      rx      = 8'h00;
      rx_par  = 1'b0;
      rx_stop = 1'b0;
      Data_Valid = hold_dv;
      P_DATA     = next_d;
      for (int c = 0; c < nbits * p; c++) begin
         @(negedge CLK);
         k = c / p;
         if (k == 0)                  exp_bit = 1'b0;
         else if (k <= 8)             exp_bit = d[k-1];
         else if (k == 9 && pe)       exp_bit = par;
         else                         exp_bit = 1'b1;
         chk($sformatf("%s_tx_c%0d", tag, c), 32'(TX_OUT), 32'(exp_bit));
         chk($sformatf("%s_busy_c%0d", tag, c), 32'(Busy), 32'd1);
         if (c % p == p / 2) begin
            if (k >= 1 && k <= 8) rx[k-1] = TX_OUT;
            if (k == 9 && pe)     rx_par  = TX_OUT;
            if (k == nbits - 1)   rx_stop = TX_OUT;
         end
         if (c == inj) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
         end
         if (c == inj + 1) Data_Valid = 1'b0;
         if (c == rst_at) begin
            RST = 1'b1;
            @(negedge CLK);
            chk({tag, "_rst_tx"}, 32'(TX_OUT), 32'd1);
            chk({tag, "_rst_busy"}, 32'(Busy), 32'd0);
            RST = 1'b0;
            return;
         end
      end
      @(negedge CLK);
      chk({tag, "_end_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_end_tx"}, 32'(TX_OUT), 32'd1);
      chk({tag, "_rx_data"}, 32'(rx), 32'(d));
      chk({tag, "_rx_stop"}, 32'(rx_stop), 32'd1);
      if (pe) chk({tag, "_rx_par_err"}, 32'(rx_par ^ (^rx) ^ pt), 32'd0);
   endtask

   initial begin
      RST           = 1'b1;
      P_DATA        = 8'h00;
      Data_Valid    = 1'b0;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      Prescale      = 6'd16;
      step();
      RST = 1'b0;
      idle_for("reset_idle", 100);

      // Even parity, P=32
      step();
      req(8'hBB, 1'b1, 1'b0, 6'd32);
      check_frame("even_bb_p32", 8'hBB, 1'b1, 1'b0, 32, -10, -10, 1'b0, 8'h44);

      // Odd parity, P=16
      step();
      req(8'hBB, 1'b1, 1'b1, 6'd16);
      check_frame("odd_bb_p16", 8'hBB, 1'b1, 1'b1, 16, -10, -10, 1'b0, 8'h00);

      // No parity, P=8
      step();
      req(8'h00, 1'b0, 1'b0, 6'd8);
      check_frame("nopar_00_p8", 8'h00, 1'b0, 1'b0, 8, -10, -10, 1'b0, 8'hFF);

      // Odd parity on all-zero data gives a 1 parity bit
      step();
      req(8'h00, 1'b1, 1'b1, 6'd8);
      check_frame("odd_00_p8", 8'h00, 1'b1, 1'b1, 8, -10, -10, 1'b0, 8'h12);

      // Prescale below 4 clamps to 4
      step();
      req(8'hC3, 1'b0, 1'b0, 6'd2);
      check_frame("clamp2", 8'hC3, 1'b0, 1'b0, 4, -10, -10, 1'b0, 8'h00);
      step();
      req(8'h5A, 1'b1, 1'b0, 6'd0);
      check_frame("clamp0", 8'h5A, 1'b1, 1'b0, 4, -10, -10, 1'b0, 8'h00);

      // Back-to-back with Data_Valid held: exactly one idle clock between frames
      step();
      req(8'hA5, 1'b0, 1'b0, 6'd8);
      check_frame("b2b_a5", 8'hA5, 1'b0, 1'b0, 8, -10, -10, 1'b1, 8'h3C);
      step();
      check_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 8, -10, -10, 1'b0, 8'h00);

      // Request while Busy is dropped
      step();
      req(8'h55, 1'b0, 1'b0, 6'd8);
      check_frame("drop_55", 8'h55, 1'b0, 1'b0, 8, 20, -10, 1'b0, 8'h55);
      idle_for("drop_after", 30);

      // Reset during data bit 3 abandons the frame; a fresh frame is intact
      step();
      req(8'hE7, 1'b0, 1'b0, 6'd16);
      check_frame("midrst", 8'hE7, 1'b0, 1'b0, 16, -10, 70, 1'b0, 8'hE7);
      idle_for("midrst_idle", 5);
      step();
      req(8'h81, 1'b1, 1'b0, 6'd16);
      check_frame("after_rst_81", 8'h81, 1'b1, 1'b0, 16, -10, -10, 1'b0, 8'h00);

      // Reset and Data_Valid together: reset wins
      step();
      RST        = 1'b1;
      Data_Valid = 1'b1;
      P_DATA     = 8'hAA;
      step();
      RST        = 1'b0;
      Data_Valid = 1'b0;
      idle_for("rst_vs_dv", 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
